// File: rtl/neg_pipe.sv
// Purpose : pipelined two's-complement pass / negate / abs, one carry segment per stage.
// Latency : NSEG = ceil(WIDTH/SEG_W) cycles from acceptance to out_valid, 1 operand/cycle.
// Backpr. : global stall; every stage holds while out_valid & ~out_ready, in_ready = ~out_valid | out_ready.
//
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   in_valid/in_ready      operand handshake; in_data is signed, in_mode 0/3 pass, 1 negate, 2 abs
//   out_valid/out_ready    result handshake; out_data result, out_ovf unrepresentable, out_zero result == 0
module neg_pipe #(
   parameter int WIDTH = 25,
   parameter int SEG_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_ovf,
   output logic             out_zero
);

   localparam int NSEG = (WIDTH + SEG_W - 1) / SEG_W;

   logic adv;
   logic in_inv;

   // Invert when negating, or when taking abs of a negative operand.
   assign in_inv = (in_mode == 2'd1) | ((in_mode == 2'd2) & in_data[WIDTH-1]);

   for (genvar k = 0; k < NSEG; k++) begin : g_stage
      localparam int LO = k * SEG_W;
      localparam int W  = ((WIDTH - LO) < SEG_W) ? (WIDTH - LO) : SEG_W;

      logic             vld_q;
      logic [WIDTH-1:0] data_q;

      logic             src_vld;
      logic             src_inv;
      logic             src_sign;
      logic             src_cy;
      logic [WIDTH-1:0] src_data;

      logic [W-1:0]     seg_x;
      logic [W-1:0]     seg_res;
      logic [WIDTH-1:0] data_d;

      if (k == 0) begin : g_src
         // First stage injects the +1 of the two's complement as its carry-in.
         assign src_vld  = in_valid;
         assign src_inv  = in_inv;
         assign src_sign = in_data[WIDTH-1];
         assign src_cy   = in_inv;
         assign src_data = in_data;
      end else begin : g_src
         assign src_vld  = g_stage[k-1].vld_q;
         assign src_inv  = g_stage[k-1].g_mid.inv_q;
         assign src_sign = g_stage[k-1].g_mid.sign_q;
         assign src_cy   = g_stage[k-1].g_mid.cy_q;
         assign src_data = g_stage[k-1].data_q;
      end

      assign seg_x = src_inv ? ~src_data[LO +: W] : src_data[LO +: W];

      if (k < NSEG - 1) begin : g_mid
         logic       inv_q;
         logic       sign_q;
         logic       cy_q;
         logic [W:0] sum;

         assign sum     = {1'b0, seg_x} + (W+1)'(src_cy);
         assign seg_res = sum[W-1:0];

         always_ff @(posedge clk) begin
            if (rst) begin
               inv_q  <= 1'b0;
               sign_q <= 1'b0;
               cy_q   <= 1'b0;
            end else if (adv) begin
               inv_q  <= src_inv;
               sign_q <= src_sign;
               cy_q   <= sum[W];
            end
         end
      end else begin : g_last
         logic ovf_q;
         logic zero_q;

         // Top segment: the final carry-out has no consumer and is dropped.
         assign seg_res = seg_x + W'(src_cy);

         always_ff @(posedge clk) begin
            if (rst) begin
               ovf_q  <= 1'b0;
               zero_q <= 1'b0;
            end else if (adv) begin
               // Only the most-negative operand stays negative after inversion.
               ovf_q  <= src_inv & src_sign & data_d[WIDTH-1];
               zero_q <= (data_d == '0);
            end
         end
      end

      // Lower segments were completed upstream, upper segments still raw.
      always_comb begin
         data_d          = src_data;
         data_d[LO +: W] = seg_res;
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            vld_q  <= 1'b0;
            data_q <= '0;
         end else if (adv) begin
            vld_q  <= src_vld;
            data_q <= data_d;
         end
      end
   end

   assign out_valid = g_stage[NSEG-1].vld_q;
   assign out_data  = g_stage[NSEG-1].data_q;
   assign out_ovf   = g_stage[NSEG-1].g_last.ovf_q;
   assign out_zero  = g_stage[NSEG-1].g_last.zero_q;

   assign adv      = ~out_valid | out_ready;
   assign in_ready = adv;

endmodule

// File: tb/tb_neg_pipe.sv
module tb_neg_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   typedef logic [33:0] exp_t;   // {ovf, zero, data[31:0]}

   typedef struct packed {
      logic [24:0] din;
      logic [1:0]  mode;
      logic [24:0] res;
      logic        ovf;
      logic        zero;
   } vec_t;

   localparam int NRND = 10000;

   // 25/8 instance (four stages)
   logic        rst, in_valid, in_ready, out_valid, out_ready, out_ovf, out_zero;
   logic [24:0] in_data, out_data;
   logic [1:0]  in_mode;

   // 10/4 instance (three stages, short top segment)
   logic        rst_r;
   logic        a_ivld, a_irdy, a_ovld, a_ordy, a_ovf, a_zero;
   logic [9:0]  a_din, a_dout;
   logic [1:0]  a_mode;

   // 8/8 instance (single stage)
   logic        b_ivld, b_irdy, b_ovld, b_ordy, b_ovf, b_zero;
   logic [7:0]  b_din, b_dout;
   logic [1:0]  b_mode;

   int   total = 0;
   int   bad   = 0;
   exp_t q_m[$];
   exp_t q_a[$];
   exp_t q_b[$];
   bit   done_a = 1'b0;
   bit   done_b = 1'b0;
   vec_t vecs[9];

   neg_pipe #(.WIDTH(25), .SEG_W(8)) u_main (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_ovf(out_ovf), .out_zero(out_zero)
   );

   neg_pipe #(.WIDTH(10), .SEG_W(4)) u_a (
      .clk(clk), .rst(rst_r),
      .in_valid(a_ivld), .in_ready(a_irdy), .in_data(a_din), .in_mode(a_mode),
      .out_valid(a_ovld), .out_ready(a_ordy), .out_data(a_dout),
      .out_ovf(a_ovf), .out_zero(a_zero)
   );

   neg_pipe #(.WIDTH(8), .SEG_W(8)) u_b (
      .clk(clk), .rst(rst_r),
      .in_valid(b_ivld), .in_ready(b_irdy), .in_data(b_din), .in_mode(b_mode),
      .out_valid(b_ovld), .out_ready(b_ordy), .out_data(b_dout),
      .out_ovf(b_ovf), .out_zero(b_zero)
   );

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   // Plain arithmetic reference, independent of the segmented structure.
   function automatic exp_t model(input int w, input logic [31:0] d, input logic [1:0] m);
      logic [31:0] mask, r;
      logic        sign, inv;
      mask = (32'd1 << w) - 32'd1;
      sign = d[w-1];
      inv  = (m == 2'd1) || ((m == 2'd2) && sign);
      r    = inv ? ((~d + 32'd1) & mask) : (d & mask);
      return {inv & sign & r[w-1], r == 32'd0, r};
   endfunction

   function automatic logic [31:0] pick(input int w);
      logic [31:0] v;
      v = $urandom;
      case ($urandom_range(0, 7))
         0:       v = 32'd1 << (w - 1);
         1:       v = 32'd0;
         2:       v = '1;
         default: ;
      endcase
      return v & ((32'd1 << w) - 32'd1);
   endfunction

   function automatic exp_t mk(input vec_t v);
      return {v.ovf, v.zero, 7'b0, v.res};
   endfunction

   // ---------------- scoreboard monitors ----------------
   initial begin : mon_main
      exp_t e;
      forever begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            if (q_m.size() == 0) begin
               total++;
               bad++;
               $display("FAIL main_unexpected: got output %0h, expected none", out_data);
            end else begin
               e = q_m.pop_front();
               chk("main_result", {30'b0, out_ovf, out_zero, 7'b0, out_data}, {30'b0, e});
            end
         end
      end
   end

   initial begin : mon_a
      exp_t e;
      forever begin
         @(negedge clk);
         if (a_ovld && a_ordy) begin
            if (q_a.size() == 0) begin
               total++;
               bad++;
               $display("FAIL rnd10_unexpected: got output %0h, expected none", a_dout);
            end else begin
               e = q_a.pop_front();
               chk("rnd10_result", {30'b0, a_ovf, a_zero, 22'b0, a_dout}, {30'b0, e});
            end
         end
      end
   end

   initial begin : mon_b
      exp_t e;
      forever begin
         @(negedge clk);
         if (b_ovld && b_ordy) begin
            if (q_b.size() == 0) begin
               total++;
               bad++;
               $display("FAIL rnd8_unexpected: got output %0h, expected none", b_dout);
            end else begin
               e = q_b.pop_front();
               chk("rnd8_result", {30'b0, b_ovf, b_zero, 24'b0, b_dout}, {30'b0, e});
            end
         end
      end
   end

   // ---------------- random regressions ----------------
   initial begin : rst_rnd
      rst_r = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_r = 1'b0;
   end

   initial begin : drv_a
      int sent;
      bit acc;
      a_ivld = 1'b0; a_din = '0; a_mode = 2'd0; a_ordy = 1'b0;
      sent = 0; acc = 1'b0;
      repeat (5) @(posedge clk);
      for (int c = 0; c < 60000 && sent < NRND; c++) begin
         @(posedge clk); #1;
         if (acc) a_ivld = 1'b0;
         acc = 1'b0;
         if (!a_ivld && $urandom_range(0, 3) != 0) begin
            a_ivld = 1'b1;
            a_din  = 10'(pick(10));
            a_mode = 2'($urandom_range(0, 3));
         end
         a_ordy = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (a_ivld && a_irdy) begin
            q_a.push_back(model(10, 32'(a_din), a_mode));
            sent++;
            acc = 1'b1;
         end
      end
      @(posedge clk); #1;
      a_ivld = 1'b0;
      a_ordy = 1'b1;
      chk("rnd10_issued", 64'(sent), 64'(NRND));
      for (int i = 0; i < 100 && q_a.size() != 0; i++) @(posedge clk);
      @(negedge clk);
      chk("rnd10_drained", 64'(q_a.size()), 64'd0);
      done_a = 1'b1;
   end

   initial begin : drv_b
      int sent;
      bit acc;
      b_ivld = 1'b0; b_din = '0; b_mode = 2'd0; b_ordy = 1'b0;
      sent = 0; acc = 1'b0;
      repeat (5) @(posedge clk);
      for (int c = 0; c < 60000 && sent < NRND; c++) begin
         @(posedge clk); #1;
         if (acc) b_ivld = 1'b0;
         acc = 1'b0;
         if (!b_ivld && $urandom_range(0, 3) != 0) begin
            b_ivld = 1'b1;
            b_din  = 8'(pick(8));
            b_mode = 2'($urandom_range(0, 3));
         end
         b_ordy = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (b_ivld && b_irdy) begin
            q_b.push_back(model(8, 32'(b_din), b_mode));
            sent++;
            acc = 1'b1;
         end
      end
      @(posedge clk); #1;
      b_ivld = 1'b0;
      b_ordy = 1'b1;
      chk("rnd8_issued", 64'(sent), 64'(NRND));
      for (int i = 0; i < 100 && q_b.size() != 0; i++) @(posedge clk);
      @(negedge clk);
      chk("rnd8_drained", 64'(q_b.size()), 64'd0);
      done_b = 1'b1;
   end

   // ---------------- directed sequence on the 25/8 instance ----------------
   initial begin : main_seq
      int lat;
      int idx;
      bit seen;

      vecs[0] = '{din: 25'h0000005, mode: 2'd1, res: 25'h1FFFFFB, ovf: 1'b0, zero: 1'b0};
      vecs[1] = '{din: 25'h1FFFFFB, mode: 2'd2, res: 25'h0000005, ovf: 1'b0, zero: 1'b0};
      vecs[2] = '{din: 25'h0000123, mode: 2'd2, res: 25'h0000123, ovf: 1'b0, zero: 1'b0};
      vecs[3] = '{din: 25'h1FFFFFB, mode: 2'd0, res: 25'h1FFFFFB, ovf: 1'b0, zero: 1'b0};
      vecs[4] = '{din: 25'h1000000, mode: 2'd1, res: 25'h1000000, ovf: 1'b1, zero: 1'b0};
      vecs[5] = '{din: 25'h0000000, mode: 2'd1, res: 25'h0000000, ovf: 1'b0, zero: 1'b1};
      vecs[6] = '{din: 25'h1000000, mode: 2'd0, res: 25'h1000000, ovf: 1'b0, zero: 1'b0};
      vecs[7] = '{din: 25'h0ABCDEF, mode: 2'd3, res: 25'h0ABCDEF, ovf: 1'b0, zero: 1'b0};
      vecs[8] = '{din: 25'h1000000, mode: 2'd2, res: 25'h1000000, ovf: 1'b1, zero: 1'b0};

      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 2'd0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_out_data",  64'(out_data),  64'd0);
      chk("reset_out_ovf",   64'(out_ovf),   64'd0);
      chk("reset_out_zero",  64'(out_zero),  64'd0);
      chk("reset_in_ready",  64'(in_ready),  64'd1);

      // single operand: latency
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = vecs[0].din; in_mode = vecs[0].mode;
      @(negedge clk);
      chk("lat_in_ready", 64'(in_ready), 64'd1);
      q_m.push_back(mk(vecs[0]));
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1; seen = 1'b0;
      while (!seen && lat < 20) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
         else begin
            @(posedge clk);
            lat++;
         end
      end
      chk("latency", 64'(lat), 64'd4);
      repeat (2) @(posedge clk);

      // back-to-back stream with a three-cycle output stall
      idx = 0;
      for (int c = 0; c < 60 && idx < 9; c++) begin
         @(posedge clk); #1;
         in_valid  = 1'b1;
         in_data   = vecs[idx].din;
         in_mode   = vecs[idx].mode;
         out_ready = !(c >= 5 && c < 8);
         @(negedge clk);
         if (c >= 5 && c < 8) begin
            chk("stall_in_ready",  64'(in_ready),  64'd0);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_hold", {30'b0, out_ovf, out_zero, 7'b0, out_data}, {30'b0, q_m[0]});
         end
         if (in_valid && in_ready) begin
            q_m.push_back(mk(vecs[idx]));
            idx++;
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      chk("stream_issued", 64'(idx), 64'd9);
      for (int i = 0; i < 50 && q_m.size() != 0; i++) @(posedge clk);
      @(negedge clk);
      chk("stream_drained", 64'(q_m.size()), 64'd0);

      // reset with three operands in flight: they must vanish
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1;
         in_data  = 25'h0000007 + 25'(i);
         in_mode  = 2'd1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_out_data",  64'(out_data),  64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      for (int i = 0; i < 8; i++) begin
         chk("post_reset_idle", 64'(out_valid), 64'd0);
         @(negedge clk);
      end

      for (int i = 0; i < 80000 && !(done_a && done_b); i++) @(posedge clk);
      chk("random_done", 64'({done_a, done_b}), 64'd3);
      chk("main_queue_empty", 64'(q_m.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
